// File: rtl/gpreg_pkg.sv
// Shared types and default widths for the GP-register write arbiter.
// Holds the INIT/RUN state encoding used by gpreg_wr_arb.
package gpreg_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

endpackage

// File: rtl/gpreg_wr_arb_if.sv
// Requester and register-file port bundle for gpreg_wr_arb.
// master = requester/register-file side, slave = arbiter side.
interface gpreg_wr_arb_if
  import gpreg_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic          gnt0;
  logic          gnt1;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;

  modport master (
    output req0, req1,
    output addr0, addr1,
    output data0, data1,
    input  gnt0, gnt1,
    input  rf_we, rf_waddr, rf_wdata,
    input  busy
  );

  modport slave (
    input  req0, req1,
    input  addr0, addr1,
    input  data0, data1,
    output gnt0, gnt1,
    output rf_we, rf_waddr, rf_wdata,
    output busy
  );

endinterface

// File: rtl/gpreg_wr_arb_rr_arb2.sv
// Two-input round-robin pick; last=1 means requester 1 won most recently.
// Purely combinational, one-hot or zero grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/gpreg_wr_arb.sv
// Two-requester write arbiter in front of a GP register file.
// Define GPREG_ARB_INIT_EN to add a reset-time zero-fill sweep.
module gpreg_wr_arb
  import gpreg_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input logic           clk,
  input logic           reset,
  gpreg_wr_arb_if.slave bus
);

  logic          run;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          last;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

`ifdef GPREG_ARB_INIT_EN
  state_t        state;
  logic [AW-1:0] count;

  assign run = (state == RUN);
`else
  assign run = 1'b1;
`endif

  // Requests are masked during the sweep so they stay pending.
  assign req = {bus.req1, bus.req0} & {2{run}};

  rr_arb2 u_rr (
    .req  (req),
    .last (last),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      last    <= 1'b1;
`ifdef GPREG_ARB_INIT_EN
      state   <= INIT;
      count   <= '0;
`endif
    end else begin
`ifdef GPREG_ARB_INIT_EN
      if (state == INIT) begin
        we_q    <= 1'b1;
        waddr_q <= count;
        wdata_q <= '0;
        if (count == AW'(NREG - 1)) begin
          state <= RUN;
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
`else
      begin
`endif
        if (|gnt) begin
          we_q    <= 1'b1;
          waddr_q <= gnt[1] ? bus.addr1 : bus.addr0;
          wdata_q <= gnt[1] ? bus.data1 : bus.data0;
          last    <= gnt[1];
        end else begin
          we_q    <= 1'b0;
        end
      end
    end
  end

  assign bus.gnt0     = gnt[0];
  assign bus.gnt1     = gnt[1];
  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.busy     = ~run;

endmodule
